// File: rtl/noc_activity_watchdog.sv
// noc_activity_watchdog: multi-channel NoC activity monitor.
// It snoops CHANNELS buses and ends a run when the cycle budget is used up
// or when no bus has changed for IDLE_LIMIT cycles. A per-channel stalled
// flag marks each bus that has stayed unchanged for CH_IDLE_LIMIT cycles.
module noc_activity_watchdog #(
    parameter int CHANNELS      = 8,
    parameter int CH_WIDTH      = 16,
    parameter int CNT_W         = 32,
    parameter int MAX_CYCLES    = 10000,
    parameter int IDLE_LIMIT    = 100,
    parameter int CH_IDLE_LIMIT = 50
) (
    input  logic                         clk,
    input  logic                         a_rst,
    input  logic                         start,
    input  logic                         clear,
    input  logic [CHANNELS*CH_WIDTH-1:0] bus_i,
    output logic                         running_o,
    output logic                         done_o,
    output logic [1:0]                   cause_o,
    output logic [CNT_W-1:0]             cycles_o,
    output logic                         active_o,
    output logic [CHANNELS-1:0]          stalled_o
);

    localparam logic [CNT_W-1:0] MAX_LIM  = CNT_W'(MAX_CYCLES);
    localparam logic [CNT_W-1:0] G_LIM    = CNT_W'(IDLE_LIMIT);
    localparam logic [CNT_W-1:0] CH_LIM   = CNT_W'(CH_IDLE_LIMIT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state;
    logic [CH_WIDTH-1:0] snap    [CHANNELS];
    logic [CNT_W-1:0]    ch_idle [CHANNELS];
    logic [CNT_W-1:0]    g_idle;

    logic [CNT_W-1:0]    ch_idle_nxt [CHANNELS];
    logic [CHANNELS-1:0] changed;
    logic [CHANNELS-1:0] stalled_nxt;
    logic                any_change;
    logic [CNT_W-1:0]    g_idle_nxt;
    logic [CNT_W-1:0]    cycles_nxt;
    logic [1:0]          cause_nxt;

    // Idle counters stop at their limit so they can never wrap.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                  input logic [CNT_W-1:0] lim);
        return (v >= lim) ? lim : v + CNT_W'(1);
    endfunction

    // Next values for one RUN edge. The stop test uses these next values, so
    // done rises on the same edge that reaches a limit.
    always_comb begin
        changed     = '0;
        stalled_nxt = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            ch_idle_nxt[c] = '0;
            if (bus_i[c*CH_WIDTH +: CH_WIDTH] != snap[c]) begin
                changed[c] = 1'b1;
            end else begin
                ch_idle_nxt[c] = sat_inc(ch_idle[c], CH_LIM);
            end
            stalled_nxt[c] = (ch_idle_nxt[c] == CH_LIM);
        end
        any_change = |changed;
        g_idle_nxt = any_change ? '0 : sat_inc(g_idle, G_LIM);
        cycles_nxt = cycles_o + CNT_W'(1);
        cause_nxt  = {(g_idle_nxt == G_LIM), (cycles_nxt == MAX_LIM)};
    end

    // Control FSM and all state registers. Clear takes priority over start in every state.
    always_ff @(posedge clk) begin
        if (!a_rst) begin
            state     <= IDLE;
            running_o <= 1'b0;
            done_o    <= 1'b0;
            cause_o   <= '0;
            cycles_o  <= '0;
            active_o  <= 1'b0;
            stalled_o <= '0;
            g_idle    <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                snap[c]    <= '0;
                ch_idle[c] <= '0;
            end
        end else if (clear) begin
            state     <= IDLE;
            running_o <= 1'b0;
            done_o    <= 1'b0;
            cause_o   <= '0;
            cycles_o  <= '0;
            active_o  <= 1'b0;
            stalled_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    active_o <= 1'b0;
                    if (start) begin
                        for (int c = 0; c < CHANNELS; c++) begin
                            snap[c]    <= bus_i[c*CH_WIDTH +: CH_WIDTH];
                            ch_idle[c] <= '0;
                        end
                        g_idle    <= '0;
                        cycles_o  <= '0;
                        cause_o   <= '0;
                        stalled_o <= '0;
                        running_o <= 1'b1;
                        state     <= PRIME;
                    end
                end
                PRIME: begin
                    // Re-snapshot the buses so that activity around the start pulse is not counted.
                    for (int c = 0; c < CHANNELS; c++) begin
                        snap[c] <= bus_i[c*CH_WIDTH +: CH_WIDTH];
                    end
                    active_o <= 1'b0;
                    state    <= RUN;
                end
                RUN: begin
                    for (int c = 0; c < CHANNELS; c++) begin
                        if (changed[c]) begin
                            snap[c] <= bus_i[c*CH_WIDTH +: CH_WIDTH];
                        end
                        ch_idle[c] <= ch_idle_nxt[c];
                    end
                    stalled_o <= stalled_nxt;
                    g_idle    <= g_idle_nxt;
                    cycles_o  <= cycles_nxt;
                    active_o  <= any_change;
                    if (|cause_nxt) begin
                        cause_o   <= cause_nxt;
                        running_o <= 1'b0;
                        done_o    <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    active_o <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_noc_activity_watchdog.sv
// Directed and random bench for noc_activity_watchdog. A timestamp-based
// reference model predicts the outputs after every clock edge.
module tb_noc_activity_watchdog;

    localparam int CH   = 4;
    localparam int W    = 8;
    localparam int CW   = 16;
    localparam int MAXC = 20;
    localparam int IDL  = 5;
    localparam int CHL  = 3;

    localparam int S_IDLE = 0, S_PRIME = 1, S_RUN = 2, S_DONE = 3;

    logic            clk = 1'b0;
    logic            a_rst, start, clear;
    logic [CH*W-1:0] bus;
    logic            running_o, done_o, active_o;
    logic [1:0]      cause_o;
    logic [CW-1:0]   cycles_o;
    logic [CH-1:0]   stalled_o;

    always #5 clk = ~clk;

    noc_activity_watchdog #(
        .CHANNELS(CH), .CH_WIDTH(W), .CNT_W(CW),
        .MAX_CYCLES(MAXC), .IDLE_LIMIT(IDL), .CH_IDLE_LIMIT(CHL)
    ) dut (
        .clk(clk), .a_rst(a_rst), .start(start), .clear(clear), .bus_i(bus),
        .running_o(running_o), .done_o(done_o), .cause_o(cause_o),
        .cycles_o(cycles_o), .active_o(active_o), .stalled_o(stalled_o)
    );

    // Reference model: the phase of the run, the RUN-edge index k, and the edge index
    // of the most recent change on each channel and on any channel.
    int          m_phase = S_IDLE;
    int          k = 0;
    int          last_ch [CH];
    int          glast = 0;
    logic [W-1:0] m_snap [CH];
    bit          m_active = 0;
    logic [1:0]  m_cause = 2'b00;
    int          m_cycles = 0;
    logic [CH-1:0] m_stalled = '0;

    int checks = 0;
    int passed = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_edge();
        bit any;
        if (!a_rst) begin
            m_phase = S_IDLE; m_active = 0; m_cause = 2'b00; m_cycles = 0; m_stalled = '0;
            for (int c = 0; c < CH; c++) m_snap[c] = '0;
        end else if (clear) begin
            m_phase = S_IDLE; m_active = 0; m_cause = 2'b00; m_cycles = 0; m_stalled = '0;
        end else if (m_phase == S_IDLE) begin
            m_active = 0;
            if (start) begin
                for (int c = 0; c < CH; c++) m_snap[c] = bus[c*W +: W];
                m_cycles = 0; m_cause = 2'b00; m_stalled = '0;
                m_phase = S_PRIME;
            end
        end else if (m_phase == S_PRIME) begin
            for (int c = 0; c < CH; c++) begin
                m_snap[c] = bus[c*W +: W];
                last_ch[c] = 0;
            end
            k = 0; glast = 0; m_active = 0;
            m_phase = S_RUN;
        end else if (m_phase == S_RUN) begin
            k++;
            any = 0;
            for (int c = 0; c < CH; c++) begin
                if (bus[c*W +: W] != m_snap[c]) begin
                    m_snap[c] = bus[c*W +: W];
                    last_ch[c] = k;
                    any = 1;
                end
                m_stalled[c] = ((k - last_ch[c]) >= CHL);
            end
            if (any) glast = k;
            m_active = any;
            m_cycles = k;
            if (k == MAXC || (k - glast) >= IDL) begin
                m_cause = {((k - glast) >= IDL), (k == MAXC)};
                m_phase = S_DONE;
            end
        end else begin
            m_active = 0;
        end
    endtask

    // One clock edge: advance the model, then compare every output just after the edge.
    task automatic cyc();
        model_edge();
        @(posedge clk);
        #1;
        chk("running", 64'(running_o), 64'(m_phase == S_PRIME || m_phase == S_RUN));
        chk("done",    64'(done_o),    64'(m_phase == S_DONE));
        chk("cause",   64'(cause_o),   64'(m_cause));
        chk("cycles",  64'(cycles_o),  64'(m_cycles));
        chk("active",  64'(active_o),  64'(m_active));
        chk("stalled", 64'(stalled_o), 64'(m_stalled));
    endtask

    task automatic tog(input logic [CH-1:0] mask);
        for (int c = 0; c < CH; c++)
            if (mask[c]) bus[c*W +: W] = bus[c*W +: W] + 8'd1;
    endtask

    initial begin
        int cnt;
        int n;
        logic [W-1:0] r;
        a_rst = 1'b0; start = 1'b0; clear = 1'b0; bus = '0;
        for (int c = 0; c < CH; c++) begin
            last_ch[c] = 0;
            m_snap[c] = '0;
        end

        // Reset state
        cyc(); cyc();
        chk("rst_running", 64'(running_o), 64'(0));
        chk("rst_cycles",  64'(cycles_o),  64'(0));
        a_rst = 1'b1;

        // Reset during RUN, with start held while reset is asserted
        bus = 32'hA5C3_1E77;
        start = 1'b1; cyc(); start = 1'b0;
        repeat (4) begin tog(4'hF); cyc(); end
        chk("pre_rst_running", 64'(running_o), 64'(1));
        a_rst = 1'b0; start = 1'b1;
        cyc(); cyc();
        chk("rst_mid_running", 64'(running_o), 64'(0));
        chk("rst_mid_cycles",  64'(cycles_o),  64'(0));
        chk("rst_mid_stalled", 64'(stalled_o), 64'(0));
        a_rst = 1'b1; start = 1'b0;
        cyc();
        chk("rst_start_ignored", 64'(running_o), 64'(0));

        // Run-length expiry with all buses toggling
        start = 1'b1; cyc(); start = 1'b0;
        cnt = running_o ? 1 : 0;
        for (int i = 0; i < 40 && !done_o; i++) begin
            tog(4'hF); cyc();
            if (running_o) cnt++;
        end
        chk("exp_running_edges", 64'(cnt), 64'(21));
        chk("exp_done",    64'(done_o),    64'(1));
        chk("exp_cause",   64'(cause_o),   64'(2'b01));
        chk("exp_cycles",  64'(cycles_o),  64'(20));
        chk("exp_stalled", 64'(stalled_o), 64'(0));
        start = 1'b1; tog(4'hF); cyc(); start = 1'b0;
        chk("done_start_ignored", 64'(done_o), 64'(1));

        // Global quiescence with the bus frozen
        clear = 1'b1; cyc(); clear = 1'b0;
        start = 1'b1; cyc(); start = 1'b0;
        cyc();
        n = 0;
        while (!done_o && n < 30) begin cyc(); n++; end
        chk("q_edges",  64'(n),        64'(5));
        chk("q_cause",  64'(cause_o),  64'(2'b10));
        chk("q_cycles", 64'(cycles_o), 64'(5));

        // Per-channel stall on channel 2
        clear = 1'b1; cyc(); clear = 1'b0;
        start = 1'b1; cyc(); start = 1'b0;
        tog(4'hF); cyc();
        tog(4'b1011); cyc();
        tog(4'b1011); cyc();
        chk("stall_early", 64'(stalled_o), 64'(4'b0000));
        tog(4'b1011); cyc();
        chk("stall_ch2",   64'(stalled_o), 64'(4'b0100));
        chk("stall_done",  64'(done_o),    64'(0));
        tog(4'b1111); cyc();
        chk("stall_clear", 64'(stalled_o), 64'(4'b0000));

        // Both causes on the same edge
        clear = 1'b1; cyc(); clear = 1'b0;
        start = 1'b1; cyc(); start = 1'b0;
        cyc();
        for (int e = 1; e <= 15; e++) begin tog(4'hF); cyc(); end
        for (int e = 16; e <= 19; e++) cyc();
        chk("both_not_yet", 64'(done_o), 64'(0));
        cyc();
        chk("both_done",   64'(done_o),   64'(1));
        chk("both_cause",  64'(cause_o),  64'(2'b11));
        chk("both_cycles", 64'(cycles_o), 64'(20));

        // Clear beats start in DONE; a later start alone begins a new run
        start = 1'b1; clear = 1'b1; cyc();
        chk("prio_running", 64'(running_o), 64'(0));
        chk("prio_done",    64'(done_o),    64'(0));
        chk("prio_cause",   64'(cause_o),   64'(0));
        chk("prio_cycles",  64'(cycles_o),  64'(0));
        clear = 1'b0; cyc();
        chk("prio_restart", 64'(running_o), 64'(1));
        start = 1'b0;

        // Random traffic, start, clear and reset against the model
        for (int i = 0; i < 600; i++) begin
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, 3) == 0) begin
                    r = 8'($urandom_range(1, 255));
                    bus[c*W +: W] = bus[c*W +: W] ^ r;
                end
            end
            start = ($urandom_range(0, 7) == 0);
            clear = ($urandom_range(0, 39) == 0);
            a_rst = ($urandom_range(0, 99) != 0);
            cyc();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
